// File: rtl/lzc_normalizer.sv
// Two-stage pipelined mantissa normaliser. Stage 1 registers the operand and its
// leading-zero count. Stage 2 registers the exponent-clamped left shift result.
module lzc_normalizer #(
  parameter int unsigned MAN_WIDTH = 24,
  parameter int unsigned EXP_WIDTH = 8,
  parameter int unsigned TAG_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [MAN_WIDTH-1:0] in_man_i,
  input  logic [EXP_WIDTH-1:0] in_exp_i,
  input  logic [TAG_WIDTH-1:0] in_tag_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [MAN_WIDTH-1:0] out_man_o,
  output logic [EXP_WIDTH-1:0] out_exp_o,
  output logic                 out_zero_o,
  output logic                 out_denorm_o,
  output logic [TAG_WIDTH-1:0] out_tag_o
);

  localparam int unsigned CNT_WIDTH = (MAN_WIDTH > 1) ? $clog2(MAN_WIDTH) : 1;
  localparam int unsigned SH_WIDTH  = (CNT_WIDTH > EXP_WIDTH) ? CNT_WIDTH : EXP_WIDTH;

  if (MAN_WIDTH < 2) begin : g_bad_man_width
    $error("lzc_normalizer: MAN_WIDTH must be at least 2");
  end

  logic                 s1_valid;
  logic [MAN_WIDTH-1:0] s1_man;
  logic [EXP_WIDTH-1:0] s1_exp;
  logic [TAG_WIDTH-1:0] s1_tag;
  logic [CNT_WIDTH-1:0] s1_cnt;
  logic                 s1_zero;

  logic                 s2_valid;
  logic [MAN_WIDTH-1:0] s2_man;
  logic [EXP_WIDTH-1:0] s2_exp;
  logic [TAG_WIDTH-1:0] s2_tag;
  logic                 s2_zero;
  logic                 s2_denorm;

  logic                 s2_adv;
  logic                 s1_adv;
  logic                 in_fire;

  logic [CNT_WIDTH-1:0] lzc_cnt;
  logic                 lzc_found;
  logic                 lzc_zero;

  logic [SH_WIDTH-1:0]  cnt_ext;
  logic [SH_WIDTH-1:0]  exp_ext;
  logic [SH_WIDTH-1:0]  shamt;
  logic [MAN_WIDTH-1:0] norm_man;
  logic [EXP_WIDTH-1:0] norm_exp;
  logic                 norm_denorm;

  // Stage 2 frees up when it is empty or its item is taken this cycle.
  always_comb begin
    s2_adv     = !s2_valid || out_ready_i;
    s1_adv     = s1_valid && s2_adv;
    in_ready_o = !flush_i && (!s1_valid || s2_adv);
    in_fire    = in_valid_i && in_ready_o;
  end

  // Count is only meaningful for a nonzero mantissa; the all-zero case uses lzc_zero.
  always_comb begin
    lzc_cnt   = '0;
    lzc_found = 1'b0;
    lzc_zero  = ~|in_man_i;
    for (int i = int'(MAN_WIDTH) - 1; i >= 0; i--) begin
      if (!lzc_found) begin
        if (in_man_i[i]) begin
          lzc_found = 1'b1;
        end else begin
          lzc_cnt = lzc_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

  // The shift is clamped by the exponent, so the exponent subtraction never wraps.
  always_comb begin
    cnt_ext     = SH_WIDTH'(s1_cnt);
    exp_ext     = SH_WIDTH'(s1_exp);
    shamt       = (cnt_ext < exp_ext) ? cnt_ext : exp_ext;
    norm_man    = s1_man << shamt;
    norm_exp    = s1_exp - EXP_WIDTH'(shamt);
    norm_denorm = !norm_man[MAN_WIDTH-1];
    if (s1_zero) begin
      norm_man    = '0;
      norm_exp    = '0;
      norm_denorm = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_man   <= '0;
      s1_exp   <= '0;
      s1_tag   <= '0;
      s1_cnt   <= '0;
      s1_zero  <= 1'b0;
    end else begin
      if (flush_i) begin
        s1_valid <= 1'b0;
      end else if (in_ready_o) begin
        s1_valid <= in_valid_i;
      end
      if (in_fire) begin
        s1_man  <= in_man_i;
        s1_exp  <= in_exp_i;
        s1_tag  <= in_tag_i;
        s1_cnt  <= lzc_cnt;
        s1_zero <= lzc_zero;
      end
    end
  end

  // Data only loads on an advance, so outputs hold still under backpressure.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid  <= 1'b0;
      s2_man    <= '0;
      s2_exp    <= '0;
      s2_tag    <= '0;
      s2_zero   <= 1'b0;
      s2_denorm <= 1'b0;
    end else begin
      if (flush_i) begin
        s2_valid <= 1'b0;
      end else if (s2_adv) begin
        s2_valid <= s1_valid;
      end
      if (s1_adv && !flush_i) begin
        s2_man    <= norm_man;
        s2_exp    <= norm_exp;
        s2_tag    <= s1_tag;
        s2_zero   <= s1_zero;
        s2_denorm <= norm_denorm;
      end
    end
  end

  always_comb begin
    out_valid_o  = s2_valid;
    out_man_o    = s2_man;
    out_exp_o    = s2_exp;
    out_zero_o   = s2_zero;
    out_denorm_o = s2_denorm;
    out_tag_o    = s2_tag;
  end

`ifndef SYNTHESIS
  // A stalled output must not change until it is taken, flushed or reset.
  property p_hold_under_backpressure;
    @(posedge clk_i) disable iff (rst_i)
      (out_valid_o && !out_ready_i && !flush_i) |=>
        (out_valid_o && $stable(out_man_o) && $stable(out_exp_o) &&
         $stable(out_zero_o) && $stable(out_denorm_o) && $stable(out_tag_o));
  endproperty
  a_hold_under_backpressure: assert property (p_hold_under_backpressure);
`endif

endmodule

// File: tb/tb_lzc_normalizer.sv
// Scoreboard bench for lzc_normalizer: directed cases and a randomized stream with
// backpressure, flush and reset, checked against a queue-based reference model.
module tb_lzc_normalizer;

  typedef struct packed {
    logic [23:0] man;
    logic [7:0]  ex;
    logic        zero;
    logic        denorm;
    logic [3:0]  tag;
  } out_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_man = '0;
  logic [7:0]  in_exp = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_man;
  logic [7:0]  out_exp;
  logic        out_zero;
  logic        out_denorm;
  logic [3:0]  out_tag;

  out_t sb[$];
  int   n_compared = 0;
  int   n_failed = 0;

  lzc_normalizer #(.MAN_WIDTH(24), .EXP_WIDTH(8), .TAG_WIDTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_man_i(in_man), .in_exp_i(in_exp), .in_tag_i(in_tag),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_man_o(out_man), .out_exp_o(out_exp), .out_zero_o(out_zero),
    .out_denorm_o(out_denorm), .out_tag_o(out_tag)
  );

  always #5 clk = ~clk;

  function automatic out_t ref_model(input logic [23:0] man, input logic [7:0] ex,
                                     input logic [3:0] tag);
    out_t r;
    int   lz;
    int   sh;
    r.tag = tag;
    if (man == 24'd0) begin
      r.man = '0; r.ex = '0; r.zero = 1'b1; r.denorm = 1'b0;
      return r;
    end
    lz = 0;
    while (man[23 - lz] == 1'b0) lz++;
    sh = (lz < int'(ex)) ? lz : int'(ex);
    r.man    = man << sh;
    r.ex     = ex - 8'(sh);
    r.zero   = 1'b0;
    r.denorm = ~r.man[23];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_compared++;
    if (act !== req) begin
      n_failed++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Drive one item at posedge+1 and hold it until accepted; returns at posedge+1.
  task automatic applyStimulus(input logic [23:0] man, input logic [7:0] ex, input logic [3:0] tag,
                               input bit use_lit, input out_t lit);
    out_t e;
    bit   accepted;
    e = use_lit ? lit : ref_model(man, ex, tag);
    accepted = 1'b0;
    in_valid = 1'b1; in_man = man; in_exp = ex; in_tag = tag;
    for (int w = 0; w < 20 && !accepted; w++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!accepted) checkOutput("accept_timeout", 64'(accepted), 64'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int w = 0; w < 30; w++) begin
      @(posedge clk);
      if (sb.size() == 0) break;
    end
    checkOutput("drain_empty", 64'(sb.size()), 64'd0);
    #1;
  endtask

  // Monitor: pops the scoreboard on each output handshake and checks stall stability.
  initial begin : monitor
    out_t act;
    out_t held;
    out_t e;
    bit   armed;
    armed = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      act = '{man: out_man, ex: out_exp, zero: out_zero, denorm: out_denorm, tag: out_tag};
      if (rst) begin
        armed = 1'b0;
      end else begin
        if (armed) begin
          checkOutput("stall_valid", 64'(out_valid), 64'd1);
          checkOutput("stall_hold", 64'(act), 64'(held));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_output", 64'(act), 64'd0);
            if (act == '0) checkOutput("unexpected_output_valid", 64'(out_valid), 64'd0);
          end else begin
            e = sb.pop_front();
            checkOutput("result", 64'(act), 64'(e));
          end
        end
        armed = out_valid && !out_ready && !flush;
        held  = act;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    out_t lit;
    int   accepted;
    int   valid_cnt;
    bit   last_ready;
    logic [23:0] t4_man[3];
    logic [23:0] m;

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("reset_outputs", 64'({out_valid, out_man, out_exp, out_zero, out_denorm, out_tag}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // T1 with latency check
    out_ready = 1'b1;
    lit = '{man: 24'h800000, ex: 8'd5, zero: 1'b0, denorm: 1'b0, tag: 4'd3};
    applyStimulus(24'h000100, 8'd20, 4'd3, 1'b1, lit);
    @(negedge clk);
    checkOutput("latency_cycle1", 64'(out_valid), 64'd0);
    @(negedge clk);
    checkOutput("latency_cycle2", 64'(out_valid), 64'd1);
    @(posedge clk); #1;

    // T2, T3 back to back
    lit = '{man: 24'h040000, ex: 8'd0, zero: 1'b0, denorm: 1'b1, tag: 4'd5};
    applyStimulus(24'h000100, 8'd10, 4'd5, 1'b1, lit);
    lit = '{man: 24'h000001, ex: 8'd0, zero: 1'b0, denorm: 1'b1, tag: 4'd6};
    applyStimulus(24'h000001, 8'd0, 4'd6, 1'b1, lit);
    lit = '{man: 24'h000000, ex: 8'd0, zero: 1'b1, denorm: 1'b0, tag: 4'd9};
    applyStimulus(24'h000000, 8'd77, 4'd9, 1'b1, lit);
    lit = '{man: 24'h800000, ex: 8'd1, zero: 1'b0, denorm: 1'b0, tag: 4'd12};
    applyStimulus(24'h800000, 8'd1, 4'd12, 1'b1, lit);
    drain();

    // T4: backpressure with three back-to-back inputs
    t4_man[0] = 24'h001234; t4_man[1] = 24'h0000F0; t4_man[2] = 24'h400000;
    out_ready = 1'b0;
    accepted  = 0;
    last_ready = 1'b1;
    in_valid = 1'b1; in_man = t4_man[0]; in_exp = 8'd30; in_tag = 4'd0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      last_ready = in_ready;
      if (in_valid && in_ready) begin
        sb.push_back(ref_model(in_man, in_exp, in_tag));
        accepted++;
      end
      @(posedge clk); #1;
      if (accepted < 3) begin
        in_man = t4_man[accepted]; in_tag = 4'(accepted);
      end
    end
    checkOutput("t4_accepts", 64'(accepted), 64'd2);
    checkOutput("t4_ready_low", 64'(last_ready), 64'd0);
    out_ready = 1'b1;
    valid_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      valid_cnt += int'(out_valid);
      if (in_valid && in_ready) begin
        sb.push_back(ref_model(in_man, in_exp, in_tag));
        accepted++;
      end
      @(posedge clk); #1;
      if (accepted == 3) in_valid = 1'b0;
    end
    checkOutput("t4_one_per_cycle", 64'(valid_cnt), 64'd3);
    drain();

    // T5: flush with two items in flight
    out_ready = 1'b0;
    applyStimulus(24'h000321, 8'd40, 4'd1, 1'b0, lit);
    applyStimulus(24'h00F000, 8'd3, 4'd2, 1'b0, lit);
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    sb.delete();
    #1;
    flush = 1'b0;
    out_ready = 1'b1;
    valid_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      valid_cnt += int'(out_valid);
    end
    checkOutput("flush_no_stale", 64'(valid_cnt), 64'd0);
    @(posedge clk); #1;
    applyStimulus(24'h000002, 8'd100, 4'd7, 1'b0, lit);
    drain();

    // T6: reset with a full pipeline
    out_ready = 1'b0;
    applyStimulus(24'h00ABCD, 8'd9, 4'd4, 1'b0, lit);
    applyStimulus(24'h000011, 8'd200, 4'd8, 1'b0, lit);
    rst = 1'b1;
    @(posedge clk);
    sb.delete();
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("midstream_reset_outputs",
                64'({out_valid, out_man, out_exp, out_zero, out_denorm, out_tag}), 64'd0);
    checkOutput("midstream_reset_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Random stream with backpressure, occasional flush and reset
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      if (flush || rst) sb.delete();
      #1;
      m = 24'($urandom) >> $urandom_range(0, 24);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_man    = m;
      in_exp    = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 30)) : 8'($urandom);
      in_tag    = 4'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 63) == 0);
      rst       = ($urandom_range(0, 799) == 0);
      @(negedge clk);
      if (in_valid && in_ready) sb.push_back(ref_model(in_man, in_exp, in_tag));
    end
    @(posedge clk);
    if (flush || rst) sb.delete();
    #1;
    flush = 1'b0;
    rst   = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
